// File: rtl/pdm_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_decoder
//  Description : 1-bit PDM to unsigned PCM converter. Third-order CIC
//                decimator (ratio 2^LOG2_DECIMATION), saturation of the
//                single overflowing code and MSB alignment to NBITS.
//  Revision    : 1.0  initial release
// ============================================================================
module pdm_decoder #(
  parameter int LOG2_DECIMATION = 8,
  parameter int NBITS           = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid
);

  // CIC gain in bits and internal modulo-2^W datapath width
  localparam int C_G = 3 * LOG2_DECIMATION;
  localparam int C_W = C_G + 1;

  localparam logic [LOG2_DECIMATION-1:0] C_CNT_ONE  = {{(LOG2_DECIMATION-1){1'b0}}, 1'b1};
  localparam logic [LOG2_DECIMATION-1:0] C_CNT_LAST = '1;
  localparam logic [1:0]                 C_SETTLED  = 2'd3;

  // Integrators (run at the input bit rate, wrap freely)
  logic [C_W-1:0] i1_q, i1_d;
  logic [C_W-1:0] i2_q, i2_d;
  logic [C_W-1:0] i3_q, i3_d;

  // Decimation phase and start-up settle count
  logic [LOG2_DECIMATION-1:0] cnt_q, cnt_d;
  logic [1:0]                 settle_q, settle_d;

  // Strobe walking through the comb pipeline: bit 0 is the decimation
  // strobe, bits 1..2 advance comb stages 2..3, bit 3 loads the output.
  // The tag travels alongside and says whether the sample may be flagged.
  logic [3:0] stb_q, stb_d;
  logic [3:0] tag_q, tag_d;

  // Comb stage outputs and their delay registers
  logic [C_W-1:0] c1_q, c1_d, z1_q, z1_d;
  logic [C_W-1:0] c2_q, c2_d, z2_q, z2_d;
  logic [C_W-1:0] c3_q, c3_d, z3_q, z3_d;

  // Output registers
  logic [NBITS-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic [C_W-1:0]   din_ext;
  logic [C_G-1:0]   y_sat;
  logic [NBITS-1:0] y_aligned;

  assign din_ext = {{(C_W-1){1'b0}}, din};

  // Integrators, decimation counter, settle count and strobe launch
  always_comb begin
    i1_d     = i1_q;
    i2_d     = i2_q;
    i3_d     = i3_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    stb_d    = {stb_q[2:0], 1'b0};
    tag_d    = {tag_q[2:0], 1'b0};
    if (din_valid) begin
      i1_d  = i1_q + din_ext;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + C_CNT_ONE;
      if (cnt_q == C_CNT_LAST) begin
        stb_d[0] = 1'b1;
        tag_d[0] = (settle_q == C_SETTLED);
        if (settle_q != C_SETTLED) begin
          settle_d = settle_q + 2'd1;
        end
      end
    end
  end

  // Comb pipeline: one differencing stage per cycle behind the strobe
  always_comb begin
    c1_d = c1_q;
    z1_d = z1_q;
    c2_d = c2_q;
    z2_d = z2_q;
    c3_d = c3_q;
    z3_d = z3_q;
    if (stb_q[0]) begin
      c1_d = i3_q - z1_q;
      z1_d = i3_q;
    end
    if (stb_q[1]) begin
      c2_d = c1_q - z2_q;
      z2_d = c1_q;
    end
    if (stb_q[2]) begin
      c3_d = c2_q - z3_q;
      z3_d = c2_q;
    end
  end

  // Only exactly 2^G can exceed G bits, so its top bit alone selects the clip
  assign y_sat = c3_q[C_G] ? {C_G{1'b1}} : c3_q[C_G-1:0];

  generate
    if (C_G >= NBITS) begin : g_trunc
      assign y_aligned = y_sat[C_G-1 -: NBITS];
    end else begin : g_shift
      assign y_aligned = {y_sat, {(NBITS-C_G){1'b0}}};
    end
  endgenerate

  // Output load: dout follows every period, dout_valid only once settled
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = stb_q[3] & tag_q[3];
    if (stb_q[3]) begin
      dout_d = y_aligned;
    end
  end

  // State registers, cleared immediately by the asynchronous reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      cnt_q        <= '0;
      settle_q     <= '0;
      stb_q        <= '0;
      tag_q        <= '0;
      c1_q         <= '0;
      z1_q         <= '0;
      c2_q         <= '0;
      z2_q         <= '0;
      c3_q         <= '0;
      z3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      stb_q        <= stb_d;
      tag_q        <= tag_d;
      c1_q         <= c1_d;
      z1_q         <= z1_d;
      c2_q         <= c2_d;
      z2_q         <= z2_d;
      c3_q         <= c3_d;
      z3_q         <= z3_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_decoder.sv
`default_nettype none
module tb_pdm_decoder;

  localparam int     R    = 256;
  localparam longint MASK = (longint'(1) << 25) - 1;
  localparam longint FULL = longint'(1) << 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        din = 1'b0, din_valid = 1'b0;
  logic        din6 = 1'b0, din_valid6 = 1'b0;
  logic [23:0] dout, dout6;
  logic        dout_valid, dout_valid6;

  int edge_n = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  int obs_v[$], obs_c[$], exp_v[$], exp_c[$], obs6[$];

  // Reference model state: integrator sums, last four period-end snapshots
  longint m_i1, m_i2, m_i3;
  longint snap[4];
  int     m_cnt, m_per;

  pdm_decoder dut (
    .clock(clk), .reset(rst_n), .din_valid(din_valid), .din(din),
    .dout(dout), .dout_valid(dout_valid)
  );

  pdm_decoder #(.LOG2_DECIMATION(6), .NBITS(24)) dut6 (
    .clock(clk), .reset(rst_n), .din_valid(din_valid6), .din(din6),
    .dout(dout6), .dout_valid(dout_valid6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      obs_v.push_back(int'(dout));
      obs_c.push_back(edge_n);
    end
    if (dout_valid6 === 1'b1) obs6.push_back(int'(dout6));
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_i1 = 0; m_i2 = 0; m_i3 = 0;
    for (int k = 0; k < 4; k++) snap[k] = 0;
    m_cnt = 0; m_per = 0;
    exp_v.delete(); exp_c.delete();
    obs_v.delete(); obs_c.delete(); obs6.delete();
  endtask

  // Output of a period = third difference of the period-end I3 sums
  task automatic model_bit(input bit b, input int cyc);
    longint y;
    m_i3 = (m_i3 + m_i2) & MASK;
    m_i2 = (m_i2 + m_i1) & MASK;
    m_i1 = (m_i1 + longint'(b)) & MASK;
    m_cnt++;
    if (m_cnt == R) begin
      m_cnt = 0;
      m_per++;
      for (int k = 3; k > 0; k--) snap[k] = snap[k-1];
      snap[0] = m_i3;
      y = (snap[0] - 3 * snap[1] + 3 * snap[2] - snap[3]) & MASK;
      if (y >= FULL) y = FULL - 1;
      if (m_per >= 4) begin
        exp_v.push_back(int'(y));
        exp_c.push_back(cyc + 4);
      end
    end
  endtask

  task automatic step(input bit b, input bit v);
    din = b;
    din_valid = v;
    @(posedge clk);
    #1;
    if (v) model_bit(b, edge_n);
  endtask

  task automatic flush();
    repeat (6) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    din_valid6 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 24'h0) begin n_bad++; $display("FAIL reset_dout: got %h expected 000000", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    n_cmp++; if (dout6 !== 24'h0) begin n_bad++; $display("FAIL reset_dout6: got %h expected 000000", dout6); end
    @(posedge clk);
    @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    n_cmp++; if (dout !== 24'h0 || obs_v.size() != 0) begin n_bad++; $display("FAIL reset_idle: got %h/%0d pulses expected 000000/0", dout, obs_v.size()); end
  endtask

  task automatic test_zeros();
    int e_first = 0;
    do_reset();
    for (int k = 1; k <= 6 * R; k++) begin
      step(1'b0, 1'b1);
      if (k == 4 * R) e_first = edge_n;
    end
    flush();
    n_cmp++; if (obs_v.size() != 3) begin n_bad++; $display("FAIL zeros_count: got %0d expected 3", obs_v.size()); end
    if (obs_c.size() > 0) begin
      n_cmp++; if (obs_c[0] != e_first + 4) begin n_bad++; $display("FAIL zeros_latency: got %0d expected %0d", obs_c[0], e_first + 4); end
    end
    for (int k = 0; k < obs_v.size(); k++) begin
      n_cmp++; if (obs_v[k] !== 0) begin n_bad++; $display("FAIL zeros_value[%0d]: got %h expected 000000", k, obs_v[k]); end
    end
  endtask

  task automatic test_ones();
    do_reset();
    repeat (6 * R) step(1'b1, 1'b1);
    flush();
    n_cmp++; if (obs_v.size() != exp_v.size()) begin n_bad++; $display("FAIL ones_count: got %0d expected %0d", obs_v.size(), exp_v.size()); end
    for (int k = 0; k < obs_v.size() && k < exp_v.size(); k++) begin
      n_cmp++; if (obs_v[k] !== 'hFFFFFF || obs_c[k] != exp_c[k]) begin n_bad++; $display("FAIL ones[%0d]: got %h@%0d expected ffffff@%0d", k, obs_v[k], obs_c[k], exp_c[k]); end
    end
  endtask

  task automatic test_density(input int period, input int want, input string name);
    do_reset();
    for (int k = 0; k < 6 * R; k++) step((k % period) == 0, 1'b1);
    flush();
    n_cmp++; if (obs_v.size() != 3) begin n_bad++; $display("FAIL %s_count: got %0d expected 3", name, obs_v.size()); end
    for (int k = 0; k < obs_v.size() && k < exp_v.size(); k++) begin
      n_cmp++; if (obs_v[k] !== want || exp_v[k] !== want || obs_c[k] != exp_c[k]) begin n_bad++; $display("FAIL %s[%0d]: got %h@%0d expected %h@%0d", name, k, obs_v[k], obs_c[k], want, exp_c[k]); end
    end
  endtask

  task automatic test_sparse();
    int nv = 0, guard = 0;
    int gap;
    int period_edges[$];
    gap = int'($urandom_range(70));
    do_reset();
    while (nv < 6 * R && guard < 40 * R) begin
      bit v;
      v = ($urandom_range(99) >= gap);
      step((nv % 4) == 0, v);
      if (v) begin
        nv++;
        if (nv % R == 0 && nv >= 4 * R) period_edges.push_back(edge_n);
      end
      guard++;
    end
    flush();
    n_cmp++; if (obs_v.size() != 3 || nv != 6 * R) begin n_bad++; $display("FAIL sparse_count: got %0d pulses/%0d bits expected 3/%0d", obs_v.size(), nv, 6 * R); end
    for (int k = 0; k < obs_v.size() && k < period_edges.size(); k++) begin
      n_cmp++; if (obs_v[k] !== 'h400000 || obs_c[k] != period_edges[k] + 4) begin n_bad++; $display("FAIL sparse[%0d] gap=%0d: got %h@%0d expected 400000@%0d", k, gap, obs_v[k], obs_c[k], period_edges[k] + 4); end
    end
  endtask

  task automatic test_step();
    do_reset();
    repeat (5 * R) step(1'b0, 1'b1);
    repeat (5 * R) step(1'b1, 1'b1);
    flush();
    n_cmp++; if (obs_v.size() != 7) begin n_bad++; $display("FAIL step_count: got %0d expected 7", obs_v.size()); end
    for (int k = 0; k < obs_v.size() && k < exp_v.size(); k++) begin
      n_cmp++; if (obs_v[k] !== exp_v[k] || obs_c[k] != exp_c[k]) begin n_bad++; $display("FAIL step_model[%0d]: got %h@%0d expected %h@%0d", k, obs_v[k], obs_c[k], exp_v[k], exp_c[k]); end
      if (k > 0) begin
        n_cmp++; if (obs_v[k] < obs_v[k-1]) begin n_bad++; $display("FAIL step_monotonic[%0d]: got %h after %h expected non-decreasing", k, obs_v[k], obs_v[k-1]); end
      end
      if (k >= 4) begin
        n_cmp++; if (obs_v[k] !== 'hFFFFFF) begin n_bad++; $display("FAIL step_full[%0d]: got %h expected ffffff", k, obs_v[k]); end
      end
    end
  endtask

  task automatic test_random();
    int nv = 0, guard = 0;
    do_reset();
    while (nv < 6 * R && guard < 20 * R) begin
      bit v;
      v = ($urandom_range(99) >= 40);
      step(bit'($urandom_range(1)), v);
      if (v) nv++;
      guard++;
    end
    flush();
    n_cmp++; if (obs_v.size() != exp_v.size() || exp_v.size() != 3) begin n_bad++; $display("FAIL random_count: got %0d expected %0d (3)", obs_v.size(), exp_v.size()); end
    for (int k = 0; k < obs_v.size() && k < exp_v.size(); k++) begin
      n_cmp++; if (obs_v[k] !== exp_v[k] || obs_c[k] != exp_c[k]) begin n_bad++; $display("FAIL random[%0d]: got %h@%0d expected %h@%0d", k, obs_v[k], obs_c[k], exp_v[k], exp_c[k]); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int k = 0; k < 6 * R; k++) step((k % 4) == 0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_cmp++; if (obs_v.size() != 2) begin n_bad++; $display("FAIL midreset_before: got %0d expected 2", obs_v.size()); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 24'h0) begin n_bad++; $display("FAIL midreset_dout: got %h expected 000000", dout); end
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(1'b0, 1'b0);
    n_cmp++; if (obs_v.size() != 0) begin n_bad++; $display("FAIL midreset_discard: got %0d pulses expected 0", obs_v.size()); end
    for (int k = 0; k < 4 * R; k++) step((k % 4) == 0, 1'b1);
    flush();
    n_cmp++; if (obs_v.size() != 1 || exp_v.size() != 1) begin n_bad++; $display("FAIL midreset_after: got %0d expected 1", obs_v.size()); end
    for (int k = 0; k < obs_v.size() && k < exp_v.size(); k++) begin
      n_cmp++; if (obs_v[k] !== exp_v[k] || obs_c[k] != exp_c[k]) begin n_bad++; $display("FAIL midreset[%0d]: got %h@%0d expected %h@%0d", k, obs_v[k], obs_c[k], exp_v[k], exp_c[k]); end
    end
  endtask

  task automatic test_l6();
    do_reset();
    for (int k = 0; k < 10 * 64; k++) begin
      din6 = (k >= 5 * 64);
      din_valid6 = 1'b1;
      @(posedge clk);
      #1;
    end
    din_valid6 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (obs6.size() != 7) begin n_bad++; $display("FAIL l6_count: got %0d expected 7", obs6.size()); end
    for (int k = 0; k < obs6.size(); k++) begin
      if (k < 2) begin
        n_cmp++; if (obs6[k] !== 0) begin n_bad++; $display("FAIL l6_zero[%0d]: got %h expected 000000", k, obs6[k]); end
      end
      if (k > 0) begin
        n_cmp++; if (obs6[k] < obs6[k-1]) begin n_bad++; $display("FAIL l6_monotonic[%0d]: got %h after %h expected non-decreasing", k, obs6[k], obs6[k-1]); end
      end
      if (k >= 4) begin
        n_cmp++; if (obs6[k] !== 'hFFFFC0) begin n_bad++; $display("FAIL l6_full[%0d]: got %h expected ffffc0", k, obs6[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_density(2, 'h800000, "alt");
    test_density(4, 'h400000, "p1000");
    test_sparse();
    test_step();
    test_random();
    test_midreset();
    test_l6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdm_decoder.md
# pdm_decoder

Converts a 1-bit pulse-density-modulated (PDM) stream into unsigned PCM amplitude samples. It uses a 3rd-order CIC (cascaded integrator-comb) decimator followed by saturation and MSB alignment. It is the receive-side counterpart of the synth's `pdm` output modulator: it feeds a PDM microphone or loopback stream back into the `amplitude` domain for metering and self-test, and a standard PDM modulator driven by its output reproduces the same density.

## Interface
- `LOG2_DECIMATION`, default 8: decimation ratio R = 2^LOG2_DECIMATION PDM bits per output sample. Legal range 2..10.
- `NBITS`, default 24: output sample width. It matches `AMPLITUDE_BITS`.
- `clock`  in  1  system clock. All state is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately. Deassertion is synchronised externally.
- `din_valid`  in  1  strobe. `din` is consumed in every cycle where this is high. It may be high every cycle or sparse.
- `din`  in  1  PDM bit, 1 = high density.
- `dout`  out  NBITS  unsigned PCM sample, held between updates.
- `dout_valid`  out  1  one-cycle pulse marking a new `dout`.

## Operation
- G = 3*LOG2_DECIMATION is the CIC gain in bits. The internal datapath width is W = G+1. All integrator and comb arithmetic is unsigned modulo 2^W, and wrap-around is intentional and required.
- Integrators: i1, i2, i3, W bits, reset 0. Each `din_valid` cycle, all three update together from their previous values: i1 <= i1 + din, i2 <= i2 + i1, i3 <= i3 + i2. When `din_valid` is low, they hold.
- Decimation counter: LOG2_DECIMATION bits, reset 0. It increments on each `din_valid` and wraps at R-1. The `din_valid` cycle in which the counter equals R-1 completes a period. It raises the internal `dec` strobe for the next cycle.
- Comb pipeline: three stages, c1..c3. Each stage holds one delay register, W bits, reset 0.
  - A stage advances only on a `dec` strobe propagating through it.
  - One stage per cycle: c1 = i3 - z1, then z1 <= i3. c2 = c1 - z2, then z2 <= c1. c3 = c2 - z3, then z3 <= c2.
- Saturation:
  - y = c3 clipped to 2^G - 1. The only value needing a clip is exactly 2^G, which is produced by the all-ones input.
  - Alignment: if G >= NBITS, dout = y[G-1 -: NBITS]. Otherwise dout = y << (NBITS-G).
- Start-up suppression:
  - A 2-bit settle counter, reset 0, counts completed periods.
  - `dout_valid` is suppressed for the first 3 completed periods after reset; the combs are still filling.
  - `dout` still updates during suppression. From the 4th period onward, every period yields exactly one `dout_valid`.
- `din_valid` gaps are allowed anywhere, including across a period boundary. The output values depend only on the sequence of valid bits, never on their timing.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, and all integrators, combs, counters and the settle count are 0.
- Latency: call the cycle that samples the period-completing `din_valid` cycle T. `dout` and `dout_valid` become visible in cycle T+4. `dout_valid` is high for exactly that one cycle.
- Throughput: one output per R valid bits. Because R >= 4 and the comb pipeline occupies 4 cycles, successive periods never overlap in the comb pipeline, even at `din_valid` every cycle.
- Reset asserted mid-period or mid-pipeline: all state clears at once, and an in-flight output is discarded (no `dout_valid`). After deassertion, the next 3 completed periods are suppressed again.
- Output density D (fraction of ones, steady state, with R a multiple of the pattern period) gives dout = D * 2^NBITS, saturated to 2^NBITS - 1.

## Test plan
- Defaults, `din` = 0 continuously with `din_valid` = 1: no `dout_valid` for the first 3*256 bits. The first pulse comes 4 cycles after bit 1024, with `dout` = 0x000000. Every 256 bits thereafter, `dout` = 0x000000.
- Defaults, `din` = 1 continuously: the first visible `dout` is 0xFFFFFF (saturated from 2^24). All later outputs are 0xFFFFFF. The integrators wrap many times without error.
- Defaults, alternating 1,0,...: steady `dout` = 0x800000. With the repeating pattern 1,0,0,0: steady `dout` = 0x400000.
- The same 1,0,0,0 stream with `din_valid` randomly low on 0-70% of cycles: output values are identical to the dense case. Each `dout_valid` pulse comes exactly 4 cycles after the 256th valid bit of its period.
- Step from all-0 to all-1 at a period boundary after settling: the outputs are non-decreasing, and exactly 0xFFFFFF from the third post-step output onward. Repeat with `LOG2_DECIMATION` = 6, `NBITS` = 24 (G = 18, left shift 6): all-ones gives 0xFFFFC0.
- Pull `reset` low for 1 cycle, 2 cycles before an expected `dout_valid`: that pulse never appears. `dout` reads 0 immediately. The next `dout_valid` arrives only after 4 full periods post-reset.
